// File: rtl/tracer_serial_alu.sv
// rtl/tracer_serial_alu.sv - nibble-serial ALU (add/sub/fixed-point mul/max) with byte-serial result; optional saturation via TRACER_ALU_SAT_EN
module tracer_serial_alu #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [3:0] i_data,
  input  logic [1:0] i_mode,
  input  logic       i_abs,
  output logic [7:0] o_result,
  output logic       o_valid,
  output logic       o_busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int NBYTE = WIDTH / 8;
  localparam int PW    = 2 * WIDTH;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // One counter serves nibble loading, multiply iterations and byte output.
  logic [5:0]       cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       mode_q;
  logic             abs_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] res_reg;

  logic             last_nib;
  logic             exec_last;
  logic             out_last;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] add_red;
  logic [WIDTH-1:0] sub_red;
  logic [WIDTH-1:0] mul_red;
  logic [WIDTH-1:0] sel_red;
  logic [WIDTH-1:0] abs_val;
  logic [WIDTH-1:0] final_res;

  assign o_busy = (state != IDLE);

  // Phase-end flags and the shared arithmetic that feeds range reduction.
  always_comb begin
    last_nib  = (cnt == 6'(NIB - 1));
    out_last  = (cnt == 6'(NBYTE - 1));
    exec_last = (mode_q == MODE_MUL) ? (cnt == 6'(WIDTH - 1)) : 1'b1;
    sum       = a_reg + b_reg;
    diff      = a_reg - b_reg;
    max_val   = ($signed(a_reg) > $signed(b_reg)) ? a_reg : b_reg;
    // Shift-add step: the multiplier's sign bit carries negative weight.
    acc_nxt   = acc;
    if (b_reg[0]) begin
      acc_nxt = (cnt == 6'(WIDTH - 1)) ? (acc - mcand) : (acc + mcand);
    end
  end

`ifdef TRACER_ALU_SAT_EN
  logic             add_ovf;
  logic             sub_ovf;
  logic             prod_fits;
  logic [WIDTH-FRAC:0] prod_hi;

  // Clamp overflowing results to the signed range.
  always_comb begin
    add_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum[WIDTH-1] != a_reg[WIDTH-1]);
    sub_ovf   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff[WIDTH-1] != a_reg[WIDTH-1]);
    add_red   = add_ovf ? (a_reg[WIDTH-1] ? MIN_V : MAX_V) : sum;
    sub_red   = sub_ovf ? (a_reg[WIDTH-1] ? MIN_V : MAX_V) : diff;
    prod_hi   = acc_nxt[PW-1:FRAC+WIDTH-1];
    prod_fits = (&prod_hi) | ~(|prod_hi);
    mul_red   = prod_fits ? acc_nxt[FRAC +: WIDTH] : (acc_nxt[PW-1] ? MIN_V : MAX_V);
    abs_val   = (sel_red == MIN_V) ? MAX_V : (WIDTH'(0) - sel_red);
  end
`else
  // Wrap modulo 2^WIDTH: just keep the low bits of each result.
  always_comb begin
    add_red = sum;
    sub_red = diff;
    mul_red = acc_nxt[FRAC +: WIDTH];
    abs_val = WIDTH'(0) - sel_red;
  end
`endif

  // Select the reduced result for the captured mode, then apply abs.
  always_comb begin
    case (mode_q)
      MODE_ADD: sel_red = add_red;
      MODE_SUB: sel_red = sub_red;
      MODE_MUL: sel_red = mul_red;
      default:  sel_red = max_val;
    endcase
    final_res = (abs_q && sel_red[WIDTH-1]) ? abs_val : sel_red;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_valid) begin
          state_nxt = (NIB == 1) ? LOAD_B : LOAD_A;
        end
      end
      LOAD_A: begin
        if (i_valid && last_nib) begin
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (i_valid && last_nib) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (exec_last) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iterative multiply, result serialisation.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_q   <= '0;
      abs_q    <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      res_reg  <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else begin
      o_valid  <= 1'b0;
      o_result <= '0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg  <= {i_data, a_reg[WIDTH-1:4]};
            mode_q <= i_mode;
            abs_q  <= i_abs;
            cnt    <= (NIB == 1) ? 6'd0 : 6'd1;
          end
        end
        LOAD_A: begin
          if (i_valid) begin
            a_reg <= {i_data, a_reg[WIDTH-1:4]};
            cnt   <= last_nib ? 6'd0 : cnt + 6'd1;
          end
        end
        LOAD_B: begin
          if (i_valid) begin
            b_reg <= {i_data, b_reg[WIDTH-1:4]};
            if (last_nib) begin
              cnt   <= 6'd0;
              acc   <= '0;
              mcand <= {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        EXEC: begin
          if (mode_q == MODE_MUL) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            b_reg <= b_reg >> 1;
          end
          if (exec_last) begin
            res_reg <= final_res;
            cnt     <= 6'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        OUT: begin
          o_valid  <= 1'b1;
          o_result <= res_reg[7:0];
          res_reg  <= res_reg >> 8;
          cnt      <= out_last ? 6'd0 : cnt + 6'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
